// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and helpers for the iterative multiply/divide unit.
//   mdu_op_t    - RV32M funct3 encodings of the eight M-extension operations
//   mdu_state_t - control FSM states
//   is_div / rs1_signed / rs2_signed - operation decode helpers
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } mdu_state_t;

    function automatic logic is_div(input mdu_op_t op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic rs1_signed(input mdu_op_t op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic rs2_signed(input mdu_op_t op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/mdu.sv
// mdu: iterative radix-2 multiply/divide unit implementing the RV32M ops.
// Ports:
//   clk, reset_b          - rising-edge clock, async active-low reset
//   in_valid/in_ready     - request handshake; in_ready high only in IDLE
//   op, in1, in2          - funct3, rs1, rs2 (latched at accept)
//   out_valid/out_ready   - response handshake; out_valid high only in DONE
//   result, zero, sign    - registered result and ALU-style flags
// Operands are converted to magnitudes at accept; CALC runs REG_WIDTH
// unsigned steps and FIX restores the sign and picks the output half.
module mdu
    import mdu_pkg::*;
#(
    parameter int REG_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_b,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           op,
    input  logic [REG_WIDTH-1:0] in1,
    input  logic [REG_WIDTH-1:0] in2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [REG_WIDTH-1:0] result,
    output logic                 zero,
    output logic                 sign
);

    localparam int W     = REG_WIDTH;
    localparam int CNT_W = $clog2(W) + 1;
    localparam logic [W-1:0]     MOST_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    mdu_state_t       state_q, state_d;
    mdu_op_t          op_q, op_d;
    logic             neg1_q, neg1_d;
    logic             neg2_q, neg2_d;
    logic [W-1:0]     b_q, b_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     result_q, result_d;

    // Accept-time decode
    mdu_op_t      op_in;
    logic         in_neg1, in_neg2, div0, ovf;
    logic [W-1:0] mag1, mag2, special_res;

    always_comb begin
        op_in   = mdu_op_t'(op);
        in_neg1 = rs1_signed(op_in) & in1[W-1];
        in_neg2 = rs2_signed(op_in) & in2[W-1];
        mag1    = in_neg1 ? -in1 : in1;
        mag2    = in_neg2 ? -in2 : in2;
        div0    = is_div(op_in) && (in2 == '0);
        ovf     = (op_in inside {OP_DIV, OP_REM}) && (in1 == MOST_NEG) && (in2 == '1);
        special_res = '0;
        if (div0) begin
            special_res = (op_in inside {OP_DIV, OP_DIVU}) ? '1 : in1;
        end else if (op_in == OP_DIV) begin
            special_res = MOST_NEG;
        end
    end

    // One radix-2 step. acc holds {high/remainder, low/dividend-quotient}.
    logic [W:0]     mul_sum, div_shift;
    logic           div_ge;
    logic [W-1:0]   div_rem;
    logic [2*W-1:0] mul_next, div_next;

    always_comb begin
        // Multiply: add multiplicand into the upper half when the LSB is set,
        // then shift right; the carry becomes the new top bit.
        mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, b_q} : '0);
        mul_next  = {mul_sum, acc_q[W-1:1]};
        // Divide: shift the next dividend bit into the partial remainder,
        // subtract the divisor if it fits and shift the quotient bit in.
        div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
        div_ge    = div_shift >= {1'b0, b_q};
        div_rem   = div_ge ? W'(div_shift - {1'b0, b_q}) : div_shift[W-1:0];
        div_next  = {div_rem, acc_q[W-2:0], div_ge};
    end

    // Sign correction and output selection
    logic [2*W-1:0] prod;
    logic [W-1:0]   quo, rem, fix_res;

    always_comb begin
        prod = (neg1_q ^ neg2_q) ? -acc_q : acc_q;
        quo  = (neg1_q ^ neg2_q) ? -acc_q[W-1:0] : acc_q[W-1:0];
        rem  = neg1_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
        case (op_q)
            OP_MUL:                       fix_res = prod[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod[2*W-1:W];
            OP_DIV, OP_DIVU:              fix_res = quo;
            default:                      fix_res = rem;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg1_d   = neg1_q;
        neg2_d   = neg2_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d   = op_in;
                    neg1_d = in_neg1;
                    neg2_d = in_neg2;
                    b_d    = mag2;
                    acc_d  = {{W{1'b0}}, mag1};
                    cnt_d  = '0;
                    if (div0 || ovf) begin
                        result_d = special_res;
                        state_d  = DONE;
                    end else begin
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                acc_d = is_div(op_q) ? div_next : mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                result_d = fix_res;
                state_d  = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q  <= IDLE;
            op_q     <= OP_MUL;
            neg1_q   <= 1'b0;
            neg2_q   <= 1'b0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg1_q   <= neg1_d;
            neg2_q   <= neg2_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign zero      = ~|result_q;
    assign sign      = result_q[W-1];

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed scoreboard bench for mdu (REG_WIDTH = 32).
// The driver pushes {expected result, expected latency} per request; the
// monitor samples on the falling edge, measures latency, checks busy/idle
// handshake behaviour and pops/compares on every output handshake.
module tb_mdu;

    logic        clk = 1'b0;
    logic        reset_b = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'b000;
    logic [31:0] in1 = '0;
    logic [31:0] in2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        zero;
    logic        sign;

    mdu #(.REG_WIDTH(32)) dut (
        .clk       (clk),
        .reset_b   (reset_b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .sign      (sign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          lat;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   edge_n     = 0;

    always @(posedge clk) edge_n = edge_n + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared = compared + 1;
        if (act !== exp) begin
            mismatched = mismatched + 1;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: the only process that counts comparisons.
    initial begin : monitor
        int acc_edge;
        bit busy, seen, chk_idle, rst_prev;
        busy = 0; seen = 0; chk_idle = 0; rst_prev = 1;
        acc_edge = 0;
        forever begin
            @(negedge clk or negedge reset_b);
            if (!reset_b) begin
                if (rst_prev) begin
                    #1;
                    chk("reset out_valid", {31'b0, out_valid}, 32'd0);
                    chk("reset in_ready",  {31'b0, in_ready},  32'd1);
                    chk("reset result",    result,             32'd0);
                    chk("reset zero",      {31'b0, zero},      32'd1);
                    chk("reset sign",      {31'b0, sign},      32'd0);
                end
                rst_prev = 0; busy = 0; seen = 0; chk_idle = 0;
            end else begin
                rst_prev = 1;
                if (chk_idle) begin
                    chk("idle after handshake in_ready",  {31'b0, in_ready},  32'd1);
                    chk("idle after handshake out_valid", {31'b0, out_valid}, 32'd0);
                    chk_idle = 0;
                end
                if (busy && !out_valid) begin
                    chk("busy in_ready", {31'b0, in_ready}, 32'd0);
                end
                if (out_valid) begin
                    if (sb.size() == 0) begin
                        chk("unexpected out_valid", 32'd1, 32'd0);
                    end else begin
                        if (!seen) begin
                            seen = 1;
                            chk({sb[0].name, " latency"}, 32'(edge_n - acc_edge + 1), 32'(sb[0].lat));
                        end
                        chk({sb[0].name, " in_ready in DONE"}, {31'b0, in_ready}, 32'd0);
                        chk({sb[0].name, " result"}, result, sb[0].res);
                        if (out_ready) begin
                            chk({sb[0].name, " zero"}, {31'b0, zero}, {31'b0, sb[0].res == 32'd0});
                            chk({sb[0].name, " sign"}, {31'b0, sign}, {31'b0, sb[0].res[31]});
                            void'(sb.pop_front());
                            busy = 0; seen = 0; chk_idle = 1;
                        end
                    end
                end
                if (in_valid && in_ready) begin
                    acc_edge = edge_n + 1;
                    busy = 1; seen = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input int dly, input string name);
        int n;
        exp_t e;
        tick();
        op = o; in1 = a; in2 = b; in_valid = 1'b1;
        out_ready = (dly == 0);
        e.res = exp; e.lat = lat; e.name = name;
        sb.push_back(e);
        n = 0;
        while (!in_ready) begin
            tick();
            n++;
            if (n > 100) begin
                $display("FAIL %s accept timeout: in_ready 0, expected 1", name);
                $fatal(1, "accept timeout");
            end
        end
        tick();
        // Scramble inputs after accept; the unit must ignore them.
        in_valid = 1'b0; op = 3'b011; in1 = 32'hDEADBEEF; in2 = 32'h12345678;
        n = 0;
        while (!out_valid) begin
            tick();
            n++;
            if (n > 100) begin
                $display("FAIL %s output timeout: out_valid 0, expected 1", name);
                $fatal(1, "output timeout");
            end
        end
        repeat (dly) tick();
        out_ready = 1'b1;
    endtask

    initial begin : driver
        #1 reset_b = 1'b0;
        repeat (2) tick();
        reset_b = 1'b1;

        do_op(3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, 0, "MUL 7*-3");
        do_op(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34, 0, "MULH");
        do_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 0, "MULHU");
        do_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 0, "MULHSU");
        do_op(3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, 0, "DIV -7/2");
        do_op(3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, 0, "REM -7,2");
        do_op(3'b101, 32'hFFFFFFFE, 32'd2,        32'h7FFFFFFF, 34, 0, "DIVU");
        do_op(3'b111, 32'd100,      32'd7,        32'd2,        34, 0, "REMU");
        do_op(3'b100, 32'd5,        32'd0,        32'hFFFFFFFF,  1, 0, "DIV by 0");
        do_op(3'b110, 32'd5,        32'd0,        32'd5,         1, 0, "REM by 0");
        do_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000,  1, 0, "DIV ovf");
        do_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,         1, 0, "REM ovf");
        // Backpressure for 5 cycles, then a back-to-back request.
        do_op(3'b101, 32'd100,      32'd7,        32'd14,       34, 5, "DIVU bp");
        do_op(3'b111, 32'd100,      32'd7,        32'd2,        34, 0, "REMU b2b");

        // Reset in the middle of CALC, operation discarded.
        tick();
        op = 3'b000; in1 = 32'd9; in2 = 32'd9; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        #1 reset_b = 1'b0;
        repeat (3) tick();
        reset_b = 1'b1;

        do_op(3'b000, 32'd3, 32'd4, 32'd12, 34, 0, "MUL 3*4 after reset");

        repeat (5) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
